// File: rtl/dmem_pkg.sv
// ============================================================================
// Module   : dmem_pkg
// Desc     : Shared types and constants for the data-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

    typedef enum logic [2:0] {
        MT_B  = 3'b000,
        MT_H  = 3'b001,
        MT_W  = 3'b010,
        MT_BU = 3'b100,
        MT_HU = 3'b101
    } mem_type_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    localparam int PORT_MEM = 0;
    localparam int PORT_DMA = 1;

endpackage

`default_nettype wire

// File: rtl/dmem_lane_align.sv
// ============================================================================
// Module   : dmem_lane_align
// Desc     : Combinational store lane placement / strobes and load extraction.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  mem_type,
    input  logic        we,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] rdata,
    output logic        illegal,
    output logic        misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (addr_lo)
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        // addr_lo[0] is deliberately ignored for halfwords
        w_half = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    end

    always_comb begin
        mem_wdata  = wdata;
        mem_wstrb  = 4'b0000;
        rdata      = 32'd0;
        illegal    = 1'b0;
        misaligned = 1'b0;
        case (mem_type)
            MT_B, MT_BU: begin
                mem_wdata = {4{wdata[7:0]}};
                mem_wstrb = 4'b0001 << addr_lo;
                rdata     = {{24{w_byte[7] & ~mem_type[2]}}, w_byte};
                illegal   = we & mem_type[2];
            end
            MT_H, MT_HU: begin
                mem_wdata  = {2{wdata[15:0]}};
                mem_wstrb  = addr_lo[1] ? 4'b1100 : 4'b0011;
                rdata      = {{16{w_half[15] & ~mem_type[2]}}, w_half};
                illegal    = we & mem_type[2];
                misaligned = addr_lo[0];
            end
            MT_W: begin
                mem_wstrb  = 4'b1111;
                rdata      = mem_rdata;
                misaligned = |addr_lo;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Desc     : Round-robin two-port sequencer for the single-port data RAM.
// Optional : define DMEM_MISALIGN_TRAP_EN to trap misaligned H/W accesses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0]             req_we,
    input  logic [1:0][31:0]       req_addr,
    input  logic [1:0][DATA_W-1:0] req_wdata,
    input  logic [1:0][2:0]        req_type,
    output logic [1:0]             resp_valid,
    output logic [DATA_W-1:0]      resp_rdata,
    output logic                   resp_err,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    output logic [3:0]             mem_wstrb,
    input  logic [DATA_W-1:0]      mem_rdata
);

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit c_trap = 1'b1;
`else
    localparam bit c_trap = 1'b0;
`endif

    arb_state_e          r_state;
    logic                r_last_grant;
    logic                r_port;
    logic                r_we;
    logic [ADDR_W+1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [2:0]          r_type;

    logic                w_winner;
    logic                w_accept;
    logic                w_err;
    logic                w_go;
    logic                w_illegal;
    logic                w_misaligned;
    logic [DATA_W-1:0]   w_lane_wdata;
    logic [3:0]          w_lane_wstrb;
    logic [DATA_W-1:0]   w_lane_rdata;
    logic                w_unused_addr;

    // Byte-address bits above the RAM size wrap and are never looked at
    assign w_unused_addr = ^{req_addr[PORT_MEM][31:ADDR_W+2], req_addr[PORT_DMA][31:ADDR_W+2]};

    assign w_winner  = (req_valid[PORT_MEM] & req_valid[PORT_DMA]) ? ~r_last_grant
                                                                   : req_valid[PORT_DMA];
    assign w_accept  = (r_state == IDLE) & (|req_valid);
    assign req_ready = (w_accept & ~rst) ? (2'b01 << w_winner) : 2'b00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_port       <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_type       <= 3'b000;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state      <= ACCESS;
                        r_last_grant <= w_winner;
                        r_port       <= w_winner;
                        r_we         <= req_we[w_winner];
                        r_addr       <= req_addr[w_winner][ADDR_W+1:0];
                        r_wdata      <= req_wdata[w_winner];
                        r_type       <= req_type[w_winner];
                    end
                end
                ACCESS:  r_state <= RESP;
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    dmem_lane_align u_lane_align (
        .mem_type   (r_type),
        .we         (r_we),
        .addr_lo    (r_addr[1:0]),
        .wdata      (r_wdata),
        .mem_rdata  (mem_rdata),
        .mem_wdata  (w_lane_wdata),
        .mem_wstrb  (w_lane_wstrb),
        .rdata      (w_lane_rdata),
        .illegal    (w_illegal),
        .misaligned (w_misaligned)
    );

    // An errored request is answered on schedule but never touches the RAM
    assign w_err = w_illegal | (c_trap & w_misaligned);
    assign w_go  = (r_state == ACCESS) & ~w_err;

    assign mem_en    = w_go;
    assign mem_we    = w_go & r_we;
    assign mem_addr  = w_go ? r_addr[ADDR_W+1:2] : '0;
    assign mem_wdata = (w_go & r_we) ? w_lane_wdata : '0;
    assign mem_wstrb = w_go ? w_lane_wstrb : 4'b0000;

    assign resp_valid = (r_state == RESP) ? (2'b01 << r_port) : 2'b00;
    assign resp_err   = (r_state == RESP) & w_err;
    assign resp_rdata = ((r_state == RESP) & ~r_we & ~w_err) ? w_lane_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module   : tb_dmem_arbiter
// Desc     : Self-checking bench for dmem_arbiter with a byte-level memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;
    import dmem_pkg::*;

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_we;
    logic [1:0][31:0] req_addr;
    logic [1:0][31:0] req_wdata;
    logic [1:0][2:0]  req_type;
    logic [1:0]       resp_valid;
    logic [31:0]      resp_rdata;
    logic             resp_err;
    logic             mem_en;
    logic             mem_we;
    logic [13:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [3:0]       mem_wstrb;
    logic [31:0]      mem_rdata;

    dmem_arbiter #(.ADDR_W(14), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_type   (req_type),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM seen by the DUT
    logic [31:0] ram [0:16383];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wstrb[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: byte memory + cycle schedule ----------------
    logic [7:0]  bmem [0:65535];
    int          cyc = 0;
    bit          m_last = 1'b1;
    int          m_free = 0;

    bit          s_mv  [4];
    logic [13:0] s_ma  [4];
    bit          s_mwe [4];
    logic [3:0]  s_ms  [4];
    logic [31:0] s_mwd [4];
    int          s_ea  [4];
    int          s_sz  [4];
    bit          s_rv  [4];
    int          s_rp  [4];
    logic [31:0] s_rd  [4];
    bit          s_re  [4];

    logic [31:0] obs_rdata [2];
    logic        obs_err   [2];
    logic [3:0]  obs_wstrb;
    logic [13:0] obs_maddr;
    bit          saw_en;
    int          g_order [8];
    int          g_cnt;

    function automatic bit legal(input logic [2:0] t, input logic we);
        return (t == 3'd0 || t == 3'd1 || t == 3'd2 || t == 3'd4 || t == 3'd5) && !(we && t[2]);
    endfunction

    function automatic bit misal(input logic [2:0] t, input logic [1:0] lo);
        return ((t == 3'd1 || t == 3'd5) && lo[0]) || (t == 3'd2 && lo != 2'd0);
    endfunction

    function automatic int size_of(input logic [2:0] t);
        return (t[1:0] == 2'd0) ? 1 : (t[1:0] == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] t, input int ea);
        logic [31:0] raw;
        int sz;
        raw = 32'd0;
        sz  = size_of(t);
        for (int i = 0; i < sz; i++) raw = raw | (32'(bmem[(ea + i) % 65536]) << (8 * i));
        if (t == 3'd0 && raw[7])  raw = raw - 32'd256;
        if (t == 3'd1 && raw[15]) raw = raw - 32'd65536;
        return raw;
    endfunction

    always @(negedge clk) begin : p_compare
        logic [1:0]  exp_ready;
        logic [2:0]  t;
        logic        we_b;
        logic [31:0] a, d;
        bit          e;
        int          w, sz, ea, ms, ns, rs;
        cyc++;
        ms = cyc % 4;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin s_mv[i] = 1'b0; s_rv[i] = 1'b0; end
            m_last = 1'b1;
            m_free = 0;
            chk("rst_req_ready",  32'(req_ready),  32'd0);
            chk("rst_mem_en",     32'(mem_en),     32'd0);
            chk("rst_mem_we",     32'(mem_we),     32'd0);
            chk("rst_mem_wstrb",  32'(mem_wstrb),  32'd0);
            chk("rst_resp_valid", 32'(resp_valid), 32'd0);
            chk("rst_resp_rdata", resp_rdata,      32'd0);
            chk("rst_resp_err",   32'(resp_err),   32'd0);
        end else begin
            exp_ready = 2'b00;
            if (cyc >= m_free && req_valid != 2'b00) begin
                w = (req_valid == 2'b11) ? (m_last ? 0 : 1) : (req_valid[1] ? 1 : 0);
                exp_ready[w] = 1'b1;
                m_last = w[0];
                m_free = cyc + 3;
                t    = req_type[w];
                we_b = req_we[w];
                a    = req_addr[w];
                d    = req_wdata[w];
                e    = !legal(t, we_b) || (TRAP && misal(t, a[1:0]));
                sz   = size_of(t);
                ea   = int'(a[15:0]) & ~(sz - 1);
                ns   = (cyc + 1) % 4;
                rs   = (cyc + 2) % 4;
                s_mv[ns]  = !e;
                s_ma[ns]  = 14'(ea / 4);
                s_mwe[ns] = we_b;
                s_ms[ns]  = 4'(((1 << sz) - 1) << (ea % 4));
                s_mwd[ns] = !we_b ? 32'd0 : (sz == 1) ? {4{d[7:0]}} : (sz == 2) ? {2{d[15:0]}} : d;
                s_ea[ns]  = ea;
                s_sz[ns]  = sz;
                s_rv[rs]  = 1'b1;
                s_rp[rs]  = w;
                s_rd[rs]  = (e || we_b) ? 32'd0 : model_load(t, ea);
                s_re[rs]  = e;
                if (we_b && !e)
                    for (int i = 0; i < sz; i++) s_mwd[ns] = s_mwd[ns]; // data placed below at commit
            end
            chk("req_ready", 32'(req_ready), 32'(exp_ready));

            if (mem_en) begin saw_en = 1'b1; obs_wstrb = mem_wstrb; obs_maddr = mem_addr; end
            if (s_mv[ms]) begin
                chk("mem_en",    32'(mem_en),    32'd1);
                chk("mem_we",    32'(mem_we),    32'(s_mwe[ms]));
                chk("mem_addr",  32'(mem_addr),  32'(s_ma[ms]));
                chk("mem_wstrb", 32'(mem_wstrb), 32'(s_ms[ms]));
                chk("mem_wdata", mem_wdata,      s_mwd[ms]);
                if (s_mwe[ms])
                    for (int i = 0; i < s_sz[ms]; i++)
                        bmem[(s_ea[ms] + i) % 65536] = s_mwd[ms][8 * ((s_ea[ms] + i) % 4) +: 8];
                s_mv[ms] = 1'b0;
            end else begin
                chk("mem_en_idle",    32'(mem_en),    32'd0);
                chk("mem_we_idle",    32'(mem_we),    32'd0);
                chk("mem_wstrb_idle", 32'(mem_wstrb), 32'd0);
            end

            for (int p = 0; p < 2; p++)
                if (resp_valid[p]) begin obs_rdata[p] = resp_rdata; obs_err[p] = resp_err; end
            if (s_rv[ms]) begin
                chk("resp_valid", 32'(resp_valid), 32'(2'b01 << s_rp[ms]));
                chk("resp_rdata", resp_rdata,      s_rd[ms]);
                chk("resp_err",   32'(resp_err),   32'(s_re[ms]));
                s_rv[ms] = 1'b0;
            end else begin
                chk("resp_valid_idle", 32'(resp_valid), 32'd0);
                chk("resp_rdata_idle", resp_rdata,      32'd0);
                chk("resp_err_idle",   32'(resp_err),   32'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_req(input int p, input logic we, input logic [2:0] t,
                          input logic [31:0] a, input logic [31:0] d);
        int k;
        @(posedge clk); #1;
        req_we[p] = we; req_type[p] = t; req_addr[p] = a; req_wdata[p] = d;
        req_valid[p] = 1'b1;
        saw_en = 1'b0;
        obs_rdata[p] = 32'h5A5A5A5A;
        obs_err[p]   = 1'bx;
        k = 0;
        do begin @(negedge clk); k++; end while (!req_ready[p] && k < 20);
        if (!req_ready[p]) chk("accept_timeout", 32'(req_ready), 32'(2'b01 << p));
        @(posedge clk); #1;
        req_valid[p] = 1'b0;
        @(negedge clk); @(negedge clk); #1;
    endtask

    task automatic run_both(input int n, input logic [2:0] t0, input logic [31:0] a0,
                            input logic [2:0] t1, input logic [31:0] a1);
        int k;
        @(posedge clk); #1;
        req_we = 2'b00;
        req_type[0] = t0; req_addr[0] = a0;
        req_type[1] = t1; req_addr[1] = a1;
        req_valid = 2'b11;
        obs_rdata[0] = 32'h5A5A5A5A;
        obs_rdata[1] = 32'h5A5A5A5A;
        g_cnt = 0;
        k = 0;
        while (g_cnt < n && k < 60) begin
            @(negedge clk); k++;
            if (req_ready[0])      begin g_order[g_cnt] = 0; g_cnt++; end
            else if (req_ready[1]) begin g_order[g_cnt] = 1; g_cnt++; end
        end
        if (g_cnt < n) chk("grant_timeout", 32'(g_cnt), 32'(n));
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
        #1;
    endtask

    initial begin : p_stim
        int k;
        for (int i = 0; i < 16384; i++) ram[i] = 32'd0;
        for (int i = 0; i < 65536; i++) bmem[i] = 8'd0;
        mem_rdata = 32'd0;
        rst = 1'b1;
        req_valid = 2'b00; req_we = 2'b00;
        req_addr = '0; req_wdata = '0; req_type = '0;
        saw_en = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;

        do_req(0, 1'b1, MT_W, 32'h100, 32'hDEADBEEF);
        chk("sw_wstrb", 32'(obs_wstrb), 32'hF);
        chk("sw_maddr", 32'(obs_maddr), 32'h40);
        do_req(0, 1'b0, MT_W, 32'h100, 32'd0);
        chk("lw_rdata", obs_rdata[0], 32'hDEADBEEF);
        chk("lw_err",   32'(obs_err[0]), 32'd0);

        do_req(0, 1'b0, MT_W, 32'h101, 32'd0);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("lw_mis_en",    32'(saw_en),       32'd0);
        chk("lw_mis_err",   32'(obs_err[0]),   32'd1);
        chk("lw_mis_rdata", obs_rdata[0],      32'd0);
`else
        chk("lw_mis_err",   32'(obs_err[0]),   32'd0);
        chk("lw_mis_rdata", obs_rdata[0],      32'hDEADBEEF);
`endif

        do_req(0, 1'b1, MT_B, 32'h103, 32'h80);
        chk("sb_wstrb", 32'(obs_wstrb), 32'h8);
        do_req(0, 1'b0, MT_B, 32'h103, 32'd0);
        chk("lb_rdata", obs_rdata[0], 32'hFFFFFF80);
        do_req(0, 1'b0, MT_BU, 32'h103, 32'd0);
        chk("lbu_rdata", obs_rdata[0], 32'h00000080);

        do_req(0, 1'b1, MT_H, 32'h202, 32'h8001);
        chk("sh_wstrb", 32'(obs_wstrb), 32'hC);
        do_req(0, 1'b0, MT_H, 32'h202, 32'd0);
        chk("lh_rdata", obs_rdata[0], 32'hFFFF8001);
        do_req(0, 1'b0, MT_HU, 32'h202, 32'd0);
        chk("lhu_rdata", obs_rdata[0], 32'h00008001);

        do_req(0, 1'b0, 3'b011, 32'h100, 32'd0);
        chk("t011_err",   32'(obs_err[0]), 32'd1);
        chk("t011_en",    32'(saw_en),     32'd0);
        do_req(0, 1'b1, MT_BU, 32'h100, 32'h55);
        chk("sbu_err",    32'(obs_err[0]), 32'd1);
        chk("sbu_en",     32'(saw_en),     32'd0);
        // Upper address bits wrap onto the same word
        do_req(0, 1'b0, MT_W, 32'h0001_0100, 32'd0);
        chk("lw_wrap", obs_rdata[0], 32'h80ADBEEF);

        do_req(1, 1'b1, MT_W, 32'h400, 32'hCAFEF00D);
        do_req(1, 1'b0, MT_HU, 32'h402, 32'd0);
        chk("dma_lhu", obs_rdata[1], 32'h0000CAFE);

        run_both(4, MT_W, 32'h400, MT_BU, 32'h400);
        for (int i = 0; i < 4; i++) chk("rr_order", 32'(g_order[i]), 32'(i % 2));
        chk("rr_p0_rdata", obs_rdata[0], 32'hCAFEF00D);
        chk("rr_p1_rdata", obs_rdata[1], 32'h0000000D);

        // Abort a store in its ACCESS cycle
        do_req(0, 1'b1, MT_W, 32'h300, 32'h11111111);
        @(posedge clk); #1;
        req_we[0] = 1'b1; req_type[0] = MT_W; req_addr[0] = 32'h300; req_wdata[0] = 32'h22222222;
        req_valid[0] = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!req_ready[0] && k < 20);
        if (!req_ready[0]) chk("abort_accept_timeout", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("async_mem_en",     32'(mem_en),     32'd0);
        chk("async_mem_we",     32'(mem_we),     32'd0);
        chk("async_resp_valid", 32'(resp_valid), 32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        run_both(2, MT_W, 32'h300, MT_W, 32'h100);
        chk("post_rst_grant0", 32'(g_order[0]), 32'd0);
        chk("post_rst_grant1", 32'(g_order[1]), 32'd1);
        chk("post_rst_p0",     obs_rdata[0],    32'h11111111);
        chk("post_rst_p1",     obs_rdata[1],    32'h80ADBEEF);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
